// File: rtl/ser_frame_arbiter_if.sv
// Bundles the two requester handshakes and the serializer-side outputs of ser_frame_arbiter.
// master = requester/serializer side, slave = the arbiter itself.
interface ser_frame_arbiter_if;
  logic        req0_valid;
  logic [49:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [49:0] req1_data;
  logic        req1_ready;
  logic [49:0] word_out;
  logic        frame_start;
  logic [1:0]  grant;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, word_out, frame_start, grant
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, word_out, frame_start, grant
  );
endinterface

// File: rtl/ser_frame_arbiter.sv
// Two-requester arbiter feeding a 50-to-10 serializer: one word per 5-cycle frame, arbitration in phase 4.
// Define SER_FRAME_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ser_frame_arbiter #(
  parameter logic [49:0] IDLE_WORD = 50'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ser_frame_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_t;

  phase_t      phase_reg, phase_next;
  logic [49:0] word_reg;
  logic [1:0]  grant_reg;
  logic        frame_start_reg;
  logic        sel0, sel1;

`ifndef SER_FRAME_ARB_FIXED_PRIO_EN
  // 0 = requester 0 granted last, 1 = requester 1 granted last
  logic        last_reg;
`endif

  always_comb begin
    phase_next = PH0;
    sel0       = 1'b0;
    sel1       = 1'b0;
    case (phase_reg)
      PH0:     phase_next = PH1;
      PH1:     phase_next = PH2;
      PH2:     phase_next = PH3;
      PH3:     phase_next = PH4;
      PH4:     phase_next = PH0;
      default: phase_next = PH0;
    endcase
    if (phase_reg == PH4) begin
`ifdef SER_FRAME_ARB_FIXED_PRIO_EN
      sel0 = bus.req0_valid;
      sel1 = bus.req1_valid & ~bus.req0_valid;
`else
      if (bus.req0_valid && bus.req1_valid) begin
        sel0 = last_reg;
        sel1 = ~last_reg;
      end else begin
        sel0 = bus.req0_valid;
        sel1 = bus.req1_valid;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg       <= PH0;
      word_reg        <= IDLE_WORD;
      grant_reg       <= 2'b00;
      frame_start_reg <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      frame_start_reg <= (phase_reg == PH4);
      if (phase_reg == PH4) begin
        if (sel0) begin
          word_reg  <= bus.req0_data;
          grant_reg <= 2'b01;
        end else if (sel1) begin
          word_reg  <= bus.req1_data;
          grant_reg <= 2'b10;
        end else begin
          word_reg  <= IDLE_WORD;
          grant_reg <= 2'b00;
        end
      end
    end
  end

`ifndef SER_FRAME_ARB_FIXED_PRIO_EN
  // Pointer moves only on an actual transfer; idle frames keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (sel0) begin
      last_reg <= 1'b0;
    end else if (sel1) begin
      last_reg <= 1'b1;
    end
  end
`endif

  assign bus.req0_ready  = sel0;
  assign bus.req1_ready  = sel1;
  assign bus.word_out    = word_reg;
  assign bus.grant       = grant_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_ser_frame_arbiter.sv
// Self-checking bench for ser_frame_arbiter: constant vector table, directed corner sequences, random vs. frame model.
module tb_ser_frame_arbiter;

  localparam logic [49:0] IDLE = 50'h3FF;
  localparam logic [49:0] DA   = 50'hA;
  localparam logic [49:0] DB   = 50'hB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ser_frame_arbiter_if bus();

  ser_frame_arbiter #(.IDLE_WORD(IDLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v0;
    logic [49:0] d0;
    logic        v1;
    logic [49:0] d1;
    logic        r0;
    logic        r1;
    logic [49:0] word;
    logic [1:0]  grant;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  // Frame-level reference state: cycle count since release, current frame contents.
  int          m_cnt;
  logic [49:0] m_word;
  logic [1:0]  m_grant;
  logic        m_fs;
  int          m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v0, input logic [49:0] d0, input logic v1, input logic [49:0] d1,
                     input logic r0, input logic r1, input logic [49:0] w, input logic [1:0] g,
                     input logic fs);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.word = w; v.grant = g; v.fs = fs;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic v0, input logic [49:0] d0, input logic v1, input logic [49:0] d1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_word  = IDLE;
    m_grant = 2'b00;
    m_fs    = 1'b0;
    m_last  = 1;
  endtask

  // Called at a negedge; ends at the following negedge with reset released from that point on.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle checked against the frame model.
  task automatic step(input logic v0, input logic [49:0] d0, input logic v1, input logic [49:0] d1);
    int ph;
    int win;
    drive(v0, d0, v1, d1);
    #1;
    ph  = m_cnt % 5;
    win = -1;
    if (ph == 4) begin
      if (v0 && v1) begin
`ifdef SER_FRAME_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (m_last == 0) ? 1 : 0;
`endif
      end else if (v0) begin
        win = 0;
      end else if (v1) begin
        win = 1;
      end
    end
    chk("model_ready0", {63'd0, bus.req0_ready}, {63'd0, (win == 0)});
    chk("model_ready1", {63'd0, bus.req1_ready}, {63'd0, (win == 1)});
    chk("model_word", {14'd0, bus.word_out}, {14'd0, m_word});
    chk("model_grant", {62'd0, bus.grant}, {62'd0, m_grant});
    chk("model_frame_start", {63'd0, bus.frame_start}, {63'd0, m_fs});
    @(posedge clk);
    if (ph == 4) begin
      if (win == 0) begin
        m_word = d0; m_grant = 2'b01; m_last = 0;
      end else if (win == 1) begin
        m_word = d1; m_grant = 2'b10; m_last = 1;
      end else begin
        m_word = IDLE; m_grant = 2'b00;
      end
    end
    m_fs = (ph == 4);
    m_cnt++;
    @(negedge clk);
  endtask

  task automatic frame_chk(input string name, input logic [49:0] w, input logic [1:0] g);
    chk({name, "_word"}, {14'd0, bus.word_out}, {14'd0, w});
    chk({name, "_grant"}, {62'd0, bus.grant}, {62'd0, g});
    chk({name, "_fs"}, {63'd0, bus.frame_start}, 64'd1);
  endtask

  initial begin
    logic [63:0] r0d, r1d;
    logic [49:0] exp_w;
    logic [1:0]  exp_g;

    // Vector table: req1-only frame, req0-only frame, idle frame, phase-2 pulse ignored.
    for (int k = 0; k < 4; k++) add(0, '0, 1, DB, 0, 0, IDLE, 2'b00, 0);
    add(0, '0, 1, DB, 0, 1, IDLE, 2'b00, 0);
    add(1, DA, 0, '0, 0, 0, DB, 2'b10, 1);
    for (int k = 0; k < 3; k++) add(1, DA, 0, '0, 0, 0, DB, 2'b10, 0);
    add(1, DA, 0, '0, 1, 0, DB, 2'b10, 0);
    add(0, '0, 0, '0, 0, 0, DA, 2'b01, 1);
    for (int k = 0; k < 4; k++) add(0, '0, 0, '0, 0, 0, DA, 2'b01, 0);
    add(0, '0, 0, '0, 0, 0, IDLE, 2'b00, 1);
    add(0, '0, 0, '0, 0, 0, IDLE, 2'b00, 0);
    add(0, '0, 1, DB, 0, 0, IDLE, 2'b00, 0);
    add(0, '0, 0, '0, 0, 0, IDLE, 2'b00, 0);
    add(0, '0, 0, '0, 0, 0, IDLE, 2'b00, 0);
    add(0, '0, 0, '0, 0, 0, IDLE, 2'b00, 1);

    // Reset state, with both valids high to show readies stay low.
    drive(1'b1, DA, 1'b1, DB);
    @(negedge clk);
    @(negedge clk);
    chk("rst_word", {14'd0, bus.word_out}, {14'd0, IDLE});
    chk("rst_grant", {62'd0, bus.grant}, 64'd0);
    chk("rst_fs", {63'd0, bus.frame_start}, 64'd0);
    chk("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_ready0", i), {63'd0, bus.req0_ready}, {63'd0, tbl[i].r0});
      chk($sformatf("tbl%0d_ready1", i), {63'd0, bus.req1_ready}, {63'd0, tbl[i].r1});
      chk($sformatf("tbl%0d_word", i), {14'd0, bus.word_out}, {14'd0, tbl[i].word});
      chk($sformatf("tbl%0d_grant", i), {62'd0, bus.grant}, {62'd0, tbl[i].grant});
      chk($sformatf("tbl%0d_fs", i), {63'd0, bus.frame_start}, {63'd0, tbl[i].fs});
      @(negedge clk);
    end

    // Continuous contention, data 1 and 2.
    do_reset();
    repeat (5) step(1, 50'h1, 1, 50'h2);
    for (int f = 0; f < 4; f++) begin
`ifdef SER_FRAME_ARB_FIXED_PRIO_EN
      exp_w = 50'h1; exp_g = 2'b01;
`else
      exp_w = (f % 2 == 0) ? 50'h1 : 50'h2;
      exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
`endif
      frame_chk($sformatf("contend%0d", f), exp_w, exp_g);
      repeat (5) step(1, 50'h1, 1, 50'h2);
    end

    // req1 alone for one frame, then contention: pointer must have moved to req1.
    do_reset();
    repeat (5) step(0, '0, 1, DB);
    frame_chk("ptr0", DB, 2'b10);
    repeat (5) step(1, DA, 1, DB);
    frame_chk("ptr1", DA, 2'b01);
    repeat (5) step(1, DA, 1, DB);
`ifdef SER_FRAME_ARB_FIXED_PRIO_EN
    frame_chk("ptr2", DA, 2'b01);
`else
    frame_chk("ptr2", DB, 2'b10);
`endif

    // Reset asserted in phase 3 of a requester-0 frame.
    do_reset();
    repeat (5) step(1, 50'h1, 1, 50'h2);
    repeat (3) step(1, 50'h1, 1, 50'h2);
    chk("midrst_pre_word", {14'd0, bus.word_out}, 64'h1);
    chk("midrst_pre_grant", {62'd0, bus.grant}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_word", {14'd0, bus.word_out}, {14'd0, IDLE});
    chk("midrst_grant", {62'd0, bus.grant}, 64'd0);
    chk("midrst_fs", {63'd0, bus.frame_start}, 64'd0);
    chk("midrst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    chk("midrst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) step(1, 50'h1, 1, 50'h2);
    frame_chk("midrst_first", 50'h1, 2'b01);
    repeat (5) step(1, 50'h1, 1, 50'h2);

    // Random traffic against the frame model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0d = {$urandom(), $urandom()};
      r1d = {$urandom(), $urandom()};
      step(1'($urandom_range(0, 1)), r0d[49:0], 1'($urandom_range(0, 1)), r1d[49:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_frame_arbiter.md
SER_FRAME_ARBITER -- requirements
Module: ser_frame_arbiter

Interface
REQ-001 Parameter IDLE_WORD, default 50'h0, is the word driven when no requester is granted.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 offers a word.
REQ-005 req0_data  input  50  requester 0 word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 offers a word.
REQ-008 req1_data  input  50  requester 1 word.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 word_out  output  50  word presented to the 50-to-10 serializer; held stable for one 5-cycle frame.
REQ-011 frame_start  output  1  high for one cycle in phase 0 of each new frame.
REQ-012 grant  output  2  source of the current frame: 2'b00 idle, 2'b01 requester 0, 2'b10 requester 1.

Function
REQ-013 The block SHALL hold a 3-bit phase counter counting 0,1,2,3,4,0,... one step per clock, never exceeding 4.
REQ-014 The block SHALL arbitrate only when phase==4; readyN SHALL be 0 in phases 0-3.
REQ-015 In phase 4, readyN SHALL be combinationally 1 only for the winning requester, and only if its validN is 1; at most one ready is high.
REQ-016 A transfer occurs on the posedge where readyN and validN are both 1; word_out SHALL load reqN_data and grant SHALL load that requester's code on that edge.
REQ-017 If neither valid is high in phase 4, word_out SHALL load IDLE_WORD and grant SHALL load 2'b00 on the phase-4 edge.
REQ-018 Round-robin: with both valid, the requester not granted last SHALL win; with one valid, it wins regardless of pointer.
REQ-019 The last-grant pointer SHALL update only on a transfer; idle frames SHALL leave it unchanged.
REQ-020 word_out and grant SHALL not change in phases 0-3, even if inputs change.
REQ-021 frame_start SHALL be registered and high exactly in the cycle after each phase-4 edge (phase 0), every frame including idle ones.
REQ-022 A valid deasserted before phase 4 SHALL be ignored with no transfer; no queuing of requests between frames.
REQ-023 Requesters hold data stable while valid and not ready; the block SHALL sample data only on the transfer edge.
REQ-024 Latency: accepted word SHALL appear on word_out in the cycle immediately after the transfer edge, held 5 cycles.

Reset
REQ-025 While rst_n==0: phase=0, word_out=IDLE_WORD, grant=2'b00, frame_start=0, last-grant pointer=requester 1 (so requester 0 wins the first contention), req0_ready=req1_ready=0.
REQ-026 Assertion of rst_n mid-frame SHALL discard the frame immediately; no transfer completes during reset.
REQ-027 The first frame after reset release SHALL be an idle frame without frame_start; first arbitration in the 5th cycle after release.

Configuration
REQ-028 Macro SER_FRAME_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the pointer is unused; when undefined, round-robin per REQ-018/019 applies.

Verification
REQ-029 Both valid continuously, data0=50'h1, data1=50'h2, macro undefined -> word_out frames alternate 1,2,1,2; grant alternates 01,10; frame_start every 5 cycles.
REQ-030 Same stimulus with SER_FRAME_ARB_FIXED_PRIO_EN -> every frame word_out=50'h1, grant=01, req1_ready never 1.
REQ-031 No valid for 3 frames, IDLE_WORD=50'h3FF -> word_out=50'h3FF, grant=00, readies 0, frame_start still every 5 cycles.
REQ-032 req1_valid pulsed in phase 2 only -> no transfer, req1_ready stays 0, next frame idle.
REQ-033 rst_n dropped in phase 3 of a requester-0 frame -> word_out=IDLE_WORD, grant=00, frame_start=0 immediately; after release, first transfer at 5th cycle, requester 0 wins contention.
REQ-034 req1 only for one frame, then both valid -> req1 frame, then req0 wins (pointer updated), then req1.
